// File: rtl/irq_ack_sequencer_if.sv
// Host-side handshake of the interrupt acknowledge sequencer: presentation,
// acknowledge and error pulses.
interface irq_ack_sequencer_if;
  logic       irq_valid;
  logic [1:0] irq_grp;
  logic [3:0] irq_chan;
  logic       irq_ack;
  logic       timeout_err;
  logic       chan_err;

  modport master (
    output irq_valid, irq_grp, irq_chan, timeout_err, chan_err,
    input  irq_ack
  );

  modport slave (
    input  irq_valid, irq_grp, irq_chan, timeout_err, chan_err,
    output irq_ack
  );
endinterface

// File: rtl/irq_ack_sequencer.sv
// Latches interrupt source edges into A/B/C pending groups, presents the
// controller's winner to the host one at a time and clears it on acknowledge.
module irq_ack_sequencer #(
  parameter int NCH     = 9,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] src_a,
  input  logic [NCH-1:0] src_b,
  input  logic [NCH-1:0] src_c,
  input  logic [NCH-1:0] en,
  output logic [NCH-1:0] pend_a,
  output logic [NCH-1:0] pend_b,
  output logic [NCH-1:0] pend_c,
  input  logic           pa,
  input  logic           pb,
  input  logic           pc,
  input  logic [3:0]     chan,
  irq_ack_sequencer_if.master host
);

  typedef enum logic [1:0] {IDLE, PRESENT, CLEAR, SETTLE} state_t;

  localparam logic [4:0]     NCH_LIM  = 5'(NCH);
  localparam logic [7:0]     TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [NCH-1:0] ONE_HOT0 = NCH'(1);

  state_t         state;
  logic [NCH-1:0] prev_a, prev_b, prev_c;
  logic [1:0]     hold_grp;
  logic [3:0]     hold_chan;
  logic [7:0]     tmo_cnt;
  logic [NCH-1:0] clr_a, clr_b, clr_c;

  // Enable-low wins over everything; a fresh edge wins over the clear.
  function automatic logic [NCH-1:0] next_pend(
    input logic [NCH-1:0] pend, input logic [NCH-1:0] src,
    input logic [NCH-1:0] prev, input logic [NCH-1:0] clr,
    input logic [NCH-1:0] ena);
    return ena & ((src & ~prev) | (pend & ~clr));
  endfunction

  function automatic logic [1:0] win_grp(input logic a, input logic b, input logic c);
    return a ? 2'd1 : b ? 2'd2 : c ? 2'd3 : 2'd0;
  endfunction

  always_comb begin
    clr_a = '0;
    clr_b = '0;
    clr_c = '0;
    if (state == CLEAR) begin
      case (hold_grp)
        2'd1:    clr_a = ONE_HOT0 << hold_chan;
        2'd2:    clr_b = ONE_HOT0 << hold_chan;
        2'd3:    clr_c = ONE_HOT0 << hold_chan;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_a <= '0;
      prev_b <= '0;
      prev_c <= '0;
      pend_a <= '0;
      pend_b <= '0;
      pend_c <= '0;
    end else begin
      prev_a <= src_a;
      prev_b <= src_b;
      prev_c <= src_c;
      pend_a <= next_pend(pend_a, src_a, prev_a, clr_a, en);
      pend_b <= next_pend(pend_b, src_b, prev_b, clr_b, en);
      pend_c <= next_pend(pend_c, src_c, prev_c, clr_c, en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      hold_grp         <= '0;
      hold_chan        <= '0;
      tmo_cnt          <= '0;
      host.irq_valid   <= 1'b0;
      host.irq_grp     <= '0;
      host.irq_chan    <= '0;
      host.timeout_err <= 1'b0;
      host.chan_err    <= 1'b0;
    end else begin
      host.timeout_err <= 1'b0;
      host.chan_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (pa || pb || pc) begin
            if ({1'b0, chan} >= NCH_LIM) begin
              host.chan_err <= 1'b1;
            end else begin
              state          <= PRESENT;
              hold_grp       <= win_grp(pa, pb, pc);
              hold_chan      <= chan;
              host.irq_valid <= 1'b1;
              host.irq_grp   <= win_grp(pa, pb, pc);
              host.irq_chan  <= chan;
            end
          end
        end
        PRESENT: begin
          // Ack takes precedence over a timeout expiring on the same cycle.
          if (host.irq_ack) begin
            state          <= CLEAR;
            host.irq_valid <= 1'b0;
            host.irq_grp   <= '0;
            host.irq_chan  <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state            <= SETTLE;
            host.timeout_err <= 1'b1;
            host.irq_valid   <= 1'b0;
            host.irq_grp     <= '0;
            host.irq_chan    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        CLEAR:  state <= SETTLE;
        SETTLE: begin
          state   <= IDLE;
          tmo_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
